// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the divide issue sequencer: funct codes, bus widths,
// FSM state encoding and small funct decode helpers.
package div_issue_ctrl_pkg;

  localparam int XLEN  = 32;
  localparam int XLEN2 = 2 * XLEN;

  localparam logic [2:0] FUNCT_DIV  = 3'b100;
  localparam logic [2:0] FUNCT_DIVU = 3'b101;
  localparam logic [2:0] FUNCT_REM  = 3'b110;
  localparam logic [2:0] FUNCT_REMU = 3'b111;

  typedef enum logic [1:0] {
    DIVC_IDLE = 2'd0,
    DIVC_BUSY = 2'd1,
    DIVC_DONE = 2'd2
  } divc_state_e;

  // funct3 bit 1 selects the remainder half of the result
  function automatic logic funct_is_rem(input logic [2:0] funct);
    return funct[1];
  endfunction

  // funct3 bit 0 selects unsigned arithmetic
  function automatic logic funct_is_unsigned(input logic [2:0] funct);
    return funct[0];
  endfunction

endpackage

// File: rtl/div_special_case.sv
// Combinational detection of the two divide corner cases the Divider is never
// launched for (zero divisor, signed overflow) and their RISC-V defined results.
module div_special_case
  import div_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = XLEN
) (
  input  logic              is_rem,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic              is_special,
  output logic [DATA_W-1:0] special_res
);

  localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] MINUS_ONE = '1;

  logic signed [DATA_W-1:0] dividend_s;
  logic signed [DATA_W-1:0] divisor_s;
  logic                     div_by_zero;
  logic                     sgn_ovf;

  assign dividend_s  = $signed(op1);
  assign divisor_s   = $signed(op2);
  assign div_by_zero = (op2 == '0);
  assign sgn_ovf     = !is_unsigned && (dividend_s == MOST_NEG) && (divisor_s == MINUS_ONE);
  assign is_special  = div_by_zero | sgn_ovf;

  // Pick the architecturally defined replacement value for the selected half
  always_comb begin
    special_res = '0;
    if (div_by_zero) begin
      special_res = is_rem ? op1 : '1;
    end else if (sgn_ovf) begin
      special_res = is_rem ? '0 : MOST_NEG;
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// EX-stage divide sequencer: holds the pipeline, presents stable latched
// operands to the Divider for at least MIN_CYCLES, resolves corner cases
// locally, and hands the selected quotient/remainder back to the EX result mux.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int MIN_CYCLES = 2,
  parameter int DATA_W     = XLEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid,
  input  logic [2:0]          ex_funct,
  input  logic                ex_is_muldiv,
  input  logic [DATA_W-1:0]   ex_op1,
  input  logic [DATA_W-1:0]   ex_op2,
  input  logic                flush,
  output logic                div_en,
  output logic [2:0]          div_funct,
  output logic [DATA_W-1:0]   div_op1,
  output logic [DATA_W-1:0]   div_op2,
  input  logic                div_done,
  input  logic [2*DATA_W-1:0] div_result,
  output logic                stall_req,
  output logic                res_valid,
  output logic [DATA_W-1:0]   div_res
);

  // MIN_CYCLES is at most 15, so a 4-bit counter always suffices
  localparam int              CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MIN_CYCLES - 1);

  divc_state_e       state;
  divc_state_e       state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              start;
  logic              cnt_at_last;
  logic              busy_exit;
  logic              is_special;
  logic [DATA_W-1:0] special_res;
  logic [DATA_W-1:0] busy_res;

  assign start       = ex_valid & ex_is_muldiv & ex_funct[2] & ~flush & (state == DIVC_IDLE);
  assign stall_req   = start | (state == DIVC_BUSY);
  assign cnt_at_last = (cnt == CNT_LAST);
  assign busy_exit   = (state == DIVC_BUSY) & cnt_at_last & div_done & ~flush;
  assign busy_res    = funct_is_rem(div_funct) ? div_result[2*DATA_W-1:DATA_W]
                                               : div_result[DATA_W-1:0];

  div_special_case #(
    .DATA_W(DATA_W)
  ) u_special (
    .is_rem      (funct_is_rem(ex_funct)),
    .is_unsigned (funct_is_unsigned(ex_funct)),
    .op1         (ex_op1),
    .op2         (ex_op2),
    .is_special  (is_special),
    .special_res (special_res)
  );

  // Next-state decode; flush wins over everything, including div_done
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = DIVC_IDLE;
    end else begin
      case (state)
        DIVC_IDLE: if (start) state_nxt = is_special ? DIVC_DONE : DIVC_BUSY;
        DIVC_BUSY: if (cnt_at_last && div_done) state_nxt = DIVC_DONE;
        DIVC_DONE: state_nxt = DIVC_IDLE;
        default:   state_nxt = DIVC_IDLE;
      endcase
    end
  end

  // State register and settling counter (restarts at 0 on every BUSY entry)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DIVC_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if ((state == DIVC_BUSY) && (state_nxt == DIVC_BUSY)) begin
        cnt <= cnt_at_last ? cnt : cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  // Divider interface, operand latch and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_en    <= 1'b0;
      div_funct <= '0;
      div_op1   <= '0;
      div_op2   <= '0;
      res_valid <= 1'b0;
      div_res   <= '0;
    end else begin
      div_en    <= (state_nxt == DIVC_BUSY);
      res_valid <= (state_nxt == DIVC_DONE);
      if (start && !is_special) begin
        div_funct <= ex_funct;
        div_op1   <= ex_op1;
        div_op2   <= ex_op2;
      end
      if (start && is_special) begin
        div_res <= special_res;
      end else if (busy_exit) begin
        div_res <= busy_res;
      end
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed self-checking bench for div_issue_ctrl with a behavioural Divider
// whose done can be delayed, and a scoreboard of expected rd values.
module tb_div_issue_ctrl;
  import div_issue_ctrl_pkg::*;

  localparam int MIN_CYCLES = 2;
  localparam int DATA_W     = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                ex_valid;
  logic [2:0]          ex_funct;
  logic                ex_is_muldiv;
  logic [DATA_W-1:0]   ex_op1;
  logic [DATA_W-1:0]   ex_op2;
  logic                flush;
  logic                div_en;
  logic [2:0]          div_funct;
  logic [DATA_W-1:0]   div_op1;
  logic [DATA_W-1:0]   div_op2;
  logic                div_done;
  logic [2*DATA_W-1:0] div_result;
  logic                stall_req;
  logic                res_valid;
  logic [DATA_W-1:0]   div_res;

  int checks = 0;
  int errors = 0;
  int done_delay = 0;
  int busy_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  div_issue_ctrl #(
    .MIN_CYCLES(MIN_CYCLES),
    .DATA_W    (DATA_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .ex_funct    (ex_funct),
    .ex_is_muldiv(ex_is_muldiv),
    .ex_op1      (ex_op1),
    .ex_op2      (ex_op2),
    .flush       (flush),
    .div_en      (div_en),
    .div_funct   (div_funct),
    .div_op1     (div_op1),
    .div_op2     (div_op2),
    .div_done    (div_done),
    .div_result  (div_result),
    .stall_req   (stall_req),
    .res_valid   (res_valid),
    .div_res     (div_res)
  );

  always #5 clk = ~clk;

  // Behavioural Divider: result from its own (latched) inputs, RISC-V semantics
  function automatic logic [63:0] div_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = '1; r = a;
    end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0;
    end else if (f[0]) begin
      q = a / b; r = a % b;
    end else begin
      q = sa / sb; r = sa % sb;
    end
    return {r, q};
  endfunction

  always @(posedge clk) busy_cnt <= div_en ? busy_cnt + 1 : 0;

  always_comb begin
    div_result = div_model(div_funct, div_op1, div_op2);
    div_done   = (done_delay == 0) ? 1'b1 : (div_en && (busy_cnt >= done_delay));
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Issue one divide at the current cycle (called just after a rising edge)
  task automatic issue(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expv, input bit special,
                       input int dly);
    int  lat;
    int  exp_lat;
    bit  stall_ok;
    bit  en_ok;
    bit  got;
    logic [31:0] popped;
    done_delay = dly;
    exp_q.push_back(expv);
    exp_lat = special ? 1 : 1 + ((MIN_CYCLES > dly + 1) ? MIN_CYCLES : dly + 1);
    ex_valid = 1'b1; ex_is_muldiv = 1'b1; ex_funct = f; ex_op1 = a; ex_op2 = b;
    stall_ok = 1'b1; en_ok = 1'b1; got = 1'b0; lat = -1;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (res_valid) begin
        got = 1'b1;
        lat = c;
        if (stall_req !== 1'b0) stall_ok = 1'b0;
      end else begin
        if (stall_req !== 1'b1) stall_ok = 1'b0;
        if (special && div_en !== 1'b0) en_ok = 1'b0;
        if (!special && c > 0 &&
            (div_en !== 1'b1 || div_op1 !== a || div_op2 !== b || div_funct !== f))
          en_ok = 1'b0;
        @(posedge clk); #1;
        if (c == 0) begin
          ex_op1 = ~a; ex_op2 = b ^ 32'h5A5A_0001; ex_funct = f ^ 3'b011;
        end
      end
    end
    popped = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_got_result"}, {63'd0, got}, 64'd1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_div_res"}, div_res, popped);
    check({tag, "_stall"}, {63'd0, stall_ok}, 64'd1);
    check({tag, special ? "_div_en_low" : "_div_if_stable"}, {63'd0, en_ok}, 64'd1);
    last_res = popped;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(negedge clk);
    check({tag, "_res_valid_one_cycle"}, res_valid, 1'b0);
    check({tag, "_idle_no_stall"}, stall_req, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_funct = 3'd0; ex_is_muldiv = 1'b0;
    ex_op1 = '0; ex_op2 = '0; flush = 1'b0; last_res = '0;
    #3;
    check("rst_div_en", div_en, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_stall", stall_req, 1'b0);
    check("rst_div_res", div_res, 32'd0);
    check("rst_div_ops", {div_op1, div_op2}, 64'd0);
    check("rst_div_funct", div_funct, 3'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue("div_100_7",  FUNCT_DIV,  32'd100, 32'd7, 32'd14, 1'b0, 0);
    issue("rem_100_7",  FUNCT_REM,  32'd100, 32'd7, 32'd2,  1'b0, 0);
    issue("div_m7_2",   FUNCT_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 0);
    issue("rem_m7_2",   FUNCT_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 0);
    issue("divu_m7_2",  FUNCT_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1'b0, 0);
    issue("divu_5_0",   FUNCT_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 0);
    issue("remu_5_0",   FUNCT_REMU, 32'd5, 32'd0, 32'd5, 1'b1, 0);
    issue("div_ovf",    FUNCT_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 0);
    issue("rem_ovf",    FUNCT_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);
    issue("remu_no_ovf", FUNCT_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0);
    issue("div_delay4", FUNCT_DIV,  32'd1000, 32'd10, 32'd100, 1'b0, 4);

    // Flush in the second BUSY cycle, coinciding with div_done
    done_delay = 1;
    ex_valid = 1'b1; ex_is_muldiv = 1'b1; ex_funct = FUNCT_DIV; ex_op1 = 32'd50; ex_op2 = 32'd5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_done_same_cycle", div_done, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0; ex_valid = 1'b0;
    @(negedge clk);
    check("flush_div_en", div_en, 1'b0);
    check("flush_stall", stall_req, 1'b0);
    begin
      bit rv_seen;
      rv_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        if (res_valid !== 1'b0 || div_en !== 1'b0) rv_seen = 1'b1;
        @(negedge clk);
      end
      check("flush_no_res_valid", {63'd0, rv_seen}, 64'd0);
    end
    check("flush_div_res_kept", div_res, last_res);
    @(posedge clk); #1;

    // Non-divide M op and non-M op with a divide funct are both ignored
    ex_valid = 1'b1; ex_is_muldiv = 1'b1; ex_funct = 3'b000; ex_op1 = 32'd3; ex_op2 = 32'd0;
    @(negedge clk);
    check("mul_no_stall", stall_req, 1'b0);
    @(posedge clk); #1;
    ex_is_muldiv = 1'b0; ex_funct = FUNCT_DIVU;
    @(negedge clk);
    check("nonm_no_stall", stall_req, 1'b0);
    check("mul_no_res_valid", res_valid, 1'b0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(negedge clk);
    check("nonm_no_div_en", div_en, 1'b0);
    check("nonm_no_res_valid", res_valid, 1'b0);
    check("nonm_div_res_kept", div_res, last_res);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of BUSY
    done_delay = 10;
    ex_valid = 1'b1; ex_is_muldiv = 1'b1; ex_funct = FUNCT_DIV; ex_op1 = 32'd77; ex_op2 = 32'd7;
    @(posedge clk); #1;
    @(posedge clk); #2;
    check("pre_rst_busy", {stall_req, div_en}, 2'b11);
    rst_n = 1'b0; ex_valid = 1'b0;
    #1;
    check("arst_div_en", div_en, 1'b0);
    check("arst_div_ops", {div_op1, div_op2}, 64'd0);
    check("arst_div_funct", div_funct, 3'd0);
    check("arst_res_valid", res_valid, 1'b0);
    check("arst_div_res", div_res, 32'd0);
    check("arst_stall", stall_req, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1; done_delay = 0;
    @(posedge clk); #1;

    issue("b2b_div_9_3", FUNCT_DIV, 32'd9, 32'd3, 32'd3, 1'b0, 0);
    issue("b2b_rem_9_4", FUNCT_REM, 32'd9, 32'd4, 32'd1, 1'b0, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
